// File: rtl/exc_ctrl_if.sv
// ============================================================================
// Module      : exc_ctrl_if
// Description : MEM-stage inputs and CP0 exception/redirect report bus of the
//               exception controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exc_ctrl_if;
  // MEM stage / pipeline inputs
  logic        stall_i;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delay_slot;
  logic        mem_eret;
  logic        mem_if_adel;
  logic        mem_ri;
  logic        mem_sys;
  logic        mem_bp;
  logic        mem_ov;
  logic        mem_adel;
  logic        mem_ades;
  logic [31:0] mem_badaddr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  // report / redirect outputs
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret_o;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // The controller side drives the report
  modport master (
    input  stall_i, mem_valid, mem_pc, mem_in_delay_slot, mem_eret,
           mem_if_adel, mem_ri, mem_sys, mem_bp, mem_ov, mem_adel, mem_ades,
           mem_badaddr, hw_int, cp0_status, cp0_cause, cp0_epc,
    output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret_o,
           flush, redirect_valid, redirect_pc
  );

  // Pipeline / CP0 side
  modport slave (
    output stall_i, mem_valid, mem_pc, mem_in_delay_slot, mem_eret,
           mem_if_adel, mem_ri, mem_sys, mem_bp, mem_ov, mem_adel, mem_ades,
           mem_badaddr, hw_int, cp0_status, cp0_cause, cp0_epc,
    input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret_o,
           flush, redirect_valid, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// Module      : exc_ctrl
// Description : MEM/commit-point exception and ERET controller. Resolves
//               exception priority, samples interrupts, and issues a one-cycle
//               CP0 report together with pipeline flush and fetch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       resetn,
  exc_ctrl_if.master bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [5:0]  int_meta, int_s;
  logic [5:0]  int_pend;
  logic        int_take;
  logic        slot;
  logic        exc_any;
  logic        exc_hit;
  logic        eret_hit;
  logic [4:0]  code_d;
  logic [31:0] badvaddr_d;
  logic [31:0] epc_d;

  // CP0 fields that play no role in exception decisions
  logic unused_cp0;
  assign unused_cp0 = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                        bus.cp0_cause[31:10], bus.cp0_cause[7:0]};

  // Two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_meta <= '0;
      int_s    <= '0;
    end else begin
      int_meta <= bus.hw_int;
      int_s    <= int_meta;
    end
  end

  assign int_pend = (int_s & bus.cp0_status[15:10])
                  | {4'b0, bus.cp0_cause[9:8] & bus.cp0_status[9:8]};
  assign int_take = (|int_pend) & bus.cp0_status[0] & ~bus.cp0_status[1];
  assign slot     = (state == IDLE) & bus.mem_valid & ~bus.stall_i;
  assign epc_d    = bus.mem_in_delay_slot ? (bus.mem_pc - 32'd4) : bus.mem_pc;

  // Priority resolution of the exception sources (interrupt highest)
  always_comb begin
    exc_any    = 1'b1;
    code_d     = 5'd0;
    badvaddr_d = 32'd0;
    if (int_take) begin
      code_d = 5'd0;
    end else if (bus.mem_if_adel) begin
      code_d     = 5'd4;
      badvaddr_d = bus.mem_pc;
    end else if (bus.mem_ri) begin
      code_d = 5'd10;
    end else if (bus.mem_sys) begin
      code_d = 5'd8;
    end else if (bus.mem_bp) begin
      code_d = 5'd9;
    end else if (bus.mem_ov) begin
      code_d = 5'd12;
    end else if (bus.mem_adel) begin
      code_d     = 5'd4;
      badvaddr_d = bus.mem_badaddr;
    end else if (bus.mem_ades) begin
      code_d     = 5'd5;
      badvaddr_d = bus.mem_badaddr;
    end else begin
      exc_any = 1'b0;
    end
  end

  assign exc_hit  = slot & exc_any;
  assign eret_hit = slot & bus.mem_eret & ~exc_any;

  // FSM state and flush counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a report starts a FLUSH window that blocks detection
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (exc_hit || eret_hit) begin
          state_next = FLUSH;
          cnt_next   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (cnt != 4'd0) cnt_next = cnt - 4'd1;
        else             state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered one-cycle report; every field returns to zero afterwards
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.exc_valid      <= 1'b0;
      bus.exc_code       <= '0;
      bus.exc_pc         <= '0;
      bus.exc_bd         <= 1'b0;
      bus.exc_badvaddr   <= '0;
      bus.eret_o         <= 1'b0;
      bus.flush          <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.exc_valid      <= exc_hit;
      bus.exc_code       <= exc_hit ? code_d : 5'd0;
      bus.exc_pc         <= exc_hit ? epc_d : 32'd0;
      bus.exc_bd         <= exc_hit & bus.mem_in_delay_slot;
      bus.exc_badvaddr   <= exc_hit ? badvaddr_d : 32'd0;
      bus.eret_o         <= eret_hit;
      bus.flush          <= exc_hit | eret_hit;
      bus.redirect_valid <= exc_hit | eret_hit;
      bus.redirect_pc    <= exc_hit ? EXC_VECTOR :
                            (eret_hit ? bus.cp0_epc : 32'd0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Self-checking bench for exc_ctrl: directed vector table,
//               multi-cycle corner sequences and randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          FC  = 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exc_ctrl_if bus ();

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, dslot, eret, if_adel, ri, sys, bp, ov, adel, ades;
    logic [31:0] pc, badaddr, epc;
    logic [105:0] exp;
  } vec_t;

  function automatic logic [105:0] pk(logic v, logic [4:0] c, logic [31:0] p,
                                      logic bd, logic [31:0] b, logic e,
                                      logic f, logic rv, logic [31:0] rp);
    return {v, c, p, bd, b, e, f, rv, rp};
  endfunction

  function automatic logic [105:0] outs();
    return {bus.exc_valid, bus.exc_code, bus.exc_pc, bus.exc_bd,
            bus.exc_badvaddr, bus.eret_o, bus.flush, bus.redirect_valid,
            bus.redirect_pc};
  endfunction

  task automatic chk(input string nm, input logic [105:0] act, input logic [105:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.stall_i = 0; bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_in_delay_slot = 0;
    bus.mem_eret = 0; bus.mem_if_adel = 0; bus.mem_ri = 0; bus.mem_sys = 0;
    bus.mem_bp = 0; bus.mem_ov = 0; bus.mem_adel = 0; bus.mem_ades = 0;
    bus.mem_badaddr = 0; bus.hw_int = 0; bus.cp0_status = 0; bus.cp0_cause = 0;
    bus.cp0_epc = 0;
  endtask

  vec_t vt[11];
  int   codes[8] = '{0, 4, 10, 8, 9, 12, 4, 5};

  initial begin
    int lat, nrep, cool, first;
    logic [5:0] hist0, hist1;
    logic flags[8];
    logic [31:0] st, ca, epc_m, bva_m;
    logic [105:0] exp;

    //        valid dsl eret ifa ri sys bp ov adl ads pc            badaddr       epc
    vt[0]  = '{1,0,0,0,0,1,0,0,0,0, 32'hBFC00100, 32'h0, 32'h0,
               pk(1, 8, 32'hBFC00100, 0, 0, 0, 1, 1, VEC)};
    vt[1]  = '{1,1,0,0,0,0,0,1,0,0, 32'h80000010, 32'h0, 32'h0,
               pk(1, 12, 32'h8000000C, 1, 0, 0, 1, 1, VEC)};
    vt[2]  = '{1,0,0,0,1,0,0,0,0,1, 32'h80000020, 32'h1003, 32'h0,
               pk(1, 10, 32'h80000020, 0, 0, 0, 1, 1, VEC)};
    vt[3]  = '{1,0,0,0,0,0,0,0,0,1, 32'h80000024, 32'h1003, 32'h0,
               pk(1, 5, 32'h80000024, 0, 32'h1003, 0, 1, 1, VEC)};
    vt[4]  = '{1,0,1,0,0,0,0,0,0,0, 32'h80000030, 32'h0, 32'hBFC00200,
               pk(0, 0, 0, 0, 0, 1, 1, 1, 32'hBFC00200)};
    vt[5]  = '{1,0,1,0,0,0,0,1,0,0, 32'h80000040, 32'h0, 32'hBFC00200,
               pk(1, 12, 32'h80000040, 0, 0, 0, 1, 1, VEC)};
    vt[6]  = '{1,0,0,1,0,0,0,0,1,0, 32'h80000003, 32'h10, 32'h0,
               pk(1, 4, 32'h80000003, 0, 32'h80000003, 0, 1, 1, VEC)};
    vt[7]  = '{1,0,0,0,0,0,1,0,0,0, 32'h80001000, 32'h0, 32'h0,
               pk(1, 9, 32'h80001000, 0, 0, 0, 1, 1, VEC)};
    vt[8]  = '{1,0,0,0,0,0,0,0,1,0, 32'h80001004, 32'h2, 32'h0,
               pk(1, 4, 32'h80001004, 0, 32'h2, 0, 1, 1, VEC)};
    vt[9]  = '{0,0,0,0,0,1,0,0,0,0, 32'h80001008, 32'h0, 32'h0, '0};
    vt[10] = '{1,1,0,0,0,1,0,0,0,0, 32'h00000000, 32'h0, 32'h0,
               pk(1, 8, 32'hFFFFFFFC, 1, 0, 0, 1, 1, VEC)};

    idle_in();
    #12;
    chk("reset_state", outs(), '0);
    resetn = 1;
    tick();

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      idle_in();
      bus.mem_valid = vt[i].valid; bus.mem_in_delay_slot = vt[i].dslot;
      bus.mem_eret = vt[i].eret; bus.mem_if_adel = vt[i].if_adel;
      bus.mem_ri = vt[i].ri; bus.mem_sys = vt[i].sys; bus.mem_bp = vt[i].bp;
      bus.mem_ov = vt[i].ov; bus.mem_adel = vt[i].adel; bus.mem_ades = vt[i].ades;
      bus.mem_pc = vt[i].pc; bus.mem_badaddr = vt[i].badaddr; bus.cp0_epc = vt[i].epc;
      tick();
      chk($sformatf("vec%0d", i), outs(), vt[i].exp);
      idle_in();
      tick();
      chk($sformatf("vec%0d_after", i), outs(), '0);
    end

    // Syscall held through FLUSH: blocked one cycle, reported again after
    idle_in();
    bus.mem_valid = 1; bus.mem_sys = 1; bus.mem_pc = 32'h80002000;
    tick();
    chk("b2b_first", outs(), pk(1, 8, 32'h80002000, 0, 0, 0, 1, 1, VEC));
    tick();
    chk("b2b_blocked", outs(), '0);
    tick();
    chk("b2b_again", outs(), pk(1, 8, 32'h80002000, 0, 0, 0, 1, 1, VEC));
    idle_in();
    tick();

    // Stall suppresses detection until it releases
    bus.mem_valid = 1; bus.mem_sys = 1; bus.mem_pc = 32'h80003000; bus.stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d", i), outs(), '0);
    end
    bus.stall_i = 0;
    tick();
    chk("stall_release", outs(), pk(1, 8, 32'h80003000, 0, 0, 0, 1, 1, VEC));
    idle_in();
    tick();

    // Interrupt latency through the synchronizer
    bus.cp0_status = 32'h00000401; bus.mem_valid = 1; bus.mem_pc = 32'h80004000;
    tick(); tick(); tick();
    bus.hw_int = 6'b000001;
    lat = 0;
    while (lat < 10) begin
      tick();
      lat++;
      if (bus.exc_valid) break;
    end
    chk("int_latency", 106'(lat), 106'd3);
    chk("int_report", outs(), pk(1, 0, 32'h80004000, 0, 0, 0, 1, 1, VEC));
    idle_in();
    tick(); tick(); tick(); tick();

    // EXL set masks the interrupt
    bus.cp0_status = 32'h00000403; bus.mem_valid = 1; bus.mem_pc = 32'h80004100;
    bus.hw_int = 6'b000001;
    nrep = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.exc_valid) nrep++;
    end
    chk("int_masked_exl", 106'(nrep), 106'd0);
    idle_in();
    tick(); tick(); tick();

    // Reset mid-FLUSH clears outputs at once; new exception accepted after
    bus.mem_valid = 1; bus.mem_sys = 1; bus.mem_pc = 32'h80005000;
    tick();
    chk("pre_reset_report", outs(), pk(1, 8, 32'h80005000, 0, 0, 0, 1, 1, VEC));
    resetn = 0;
    #1;
    chk("reset_midflush", outs(), '0);
    idle_in();
    tick(); tick();
    resetn = 1;
    tick();
    chk("post_reset_idle", outs(), '0);
    bus.mem_valid = 1; bus.mem_sys = 1; bus.mem_pc = 32'h80005100;
    tick();
    chk("post_reset_report", outs(), pk(1, 8, 32'h80005100, 0, 0, 0, 1, 1, VEC));

    // Randomized run against a cooldown/priority-list reference model
    idle_in();
    resetn = 0;
    tick(); tick();
    resetn = 1;
    hist0 = '0; hist1 = '0; cool = 0;
    for (int k = 0; k < 400; k++) begin
      bus.stall_i = ($urandom_range(0, 4) == 0);
      bus.mem_valid = ($urandom_range(0, 3) != 0);
      bus.mem_pc = $urandom;
      bus.mem_in_delay_slot = $urandom_range(0, 1);
      bus.mem_eret = ($urandom_range(0, 5) == 0);
      bus.mem_if_adel = ($urandom_range(0, 15) == 0);
      bus.mem_ri = ($urandom_range(0, 15) == 0);
      bus.mem_sys = ($urandom_range(0, 15) == 0);
      bus.mem_bp = ($urandom_range(0, 15) == 0);
      bus.mem_ov = ($urandom_range(0, 15) == 0);
      bus.mem_adel = ($urandom_range(0, 15) == 0);
      bus.mem_ades = ($urandom_range(0, 15) == 0);
      bus.mem_badaddr = $urandom;
      if ($urandom_range(0, 7) == 0) bus.hw_int = 6'($urandom);
      st = $urandom;
      st[1] = ($urandom_range(0, 3) == 0);
      bus.cp0_status = st;
      ca = $urandom;
      if ($urandom_range(0, 1) == 0) ca[9:8] = 2'b00;
      bus.cp0_cause = ca;
      bus.cp0_epc = $urandom;

      exp = '0;
      if (cool > 0) begin
        cool--;
      end else if (bus.mem_valid && !bus.stall_i) begin
        flags[0] = (|((hist1 & st[15:10]) | {4'b0, ca[9:8] & st[9:8]})) && st[0] && !st[1];
        flags[1] = bus.mem_if_adel; flags[2] = bus.mem_ri; flags[3] = bus.mem_sys;
        flags[4] = bus.mem_bp; flags[5] = bus.mem_ov; flags[6] = bus.mem_adel;
        flags[7] = bus.mem_ades;
        first = -1;
        for (int j = 7; j >= 0; j--) if (flags[j]) first = j;
        if (first >= 0) begin
          epc_m = bus.mem_in_delay_slot ? bus.mem_pc - 32'd4 : bus.mem_pc;
          bva_m = (first == 1) ? bus.mem_pc : ((first >= 6) ? bus.mem_badaddr : 32'd0);
          exp = pk(1, 5'(codes[first]), epc_m, bus.mem_in_delay_slot, bva_m, 0, 1, 1, VEC);
          cool = FC;
        end else if (bus.mem_eret) begin
          exp = pk(0, 0, 0, 0, 0, 1, 1, 1, bus.cp0_epc);
          cool = FC;
        end
      end
      tick();
      chk($sformatf("rand%0d", k), outs(), exp);
      hist1 = hist0;
      hist0 = bus.hw_int;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
